// File: rtl/ycbcr_to_rgb_conv.sv
// BT.601 studio-range YCbCr to full-range RGB converter, 3-stage pipeline.
// Optional YCBCR_VALID_EN adds an in_valid/out_valid sideband aligned with the data.
module ycbcr_to_rgb_conv #(
  parameter int COEF_FRAC = 10,
  parameter int LATENCY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] y,
  input  logic [7:0] cb,
  input  logic [7:0] cr,
`ifdef YCBCR_VALID_EN
  input  logic       in_valid,
  output logic       out_valid,
`endif
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  // 9-bit signed operand times (COEF_FRAC+3)-bit coefficient, three terms summed.
  localparam int SW = COEF_FRAC + 14;

  localparam int C_Y   = int'(1.164 * 2.0 ** COEF_FRAC);
  localparam int C_CRR = int'(1.596 * 2.0 ** COEF_FRAC);
  localparam int C_CRG = int'(0.813 * 2.0 ** COEF_FRAC);
  localparam int C_CBG = int'(0.392 * 2.0 ** COEF_FRAC);
  localparam int C_CBB = int'(2.017 * 2.0 ** COEF_FRAC);

  localparam logic signed [SW-1:0] RND  = SW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(255);

  // Stage 1: offset-removed operands
  logic signed [8:0] y_o, cb_o, cr_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_o  <= '0;
      cb_o <= '0;
      cr_o <= '0;
    end else begin
      y_o  <= $signed({1'b0, y})  - 9'sd16;
      cb_o <= $signed({1'b0, cb}) - 9'sd128;
      cr_o <= $signed({1'b0, cr}) - 9'sd128;
    end
  end

  // Stage 2: products and per-channel sums
  logic signed [SW-1:0] p_y, p_crr, p_crg, p_cbg, p_cbb;
  logic signed [SW-1:0] r_sum, g_sum, b_sum;

  assign p_y   = SW'(y_o)  * SW'(C_Y);
  assign p_crr = SW'(cr_o) * SW'(C_CRR);
  assign p_crg = SW'(cr_o) * SW'(C_CRG);
  assign p_cbg = SW'(cb_o) * SW'(C_CBG);
  assign p_cbb = SW'(cb_o) * SW'(C_CBB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
      g_sum <= '0;
      b_sum <= '0;
    end else begin
      r_sum <= p_y + p_crr;
      g_sum <= p_y - p_crg - p_cbg;
      b_sum <= p_y + p_cbb;
    end
  end

  // Round half up, drop fraction, clamp to 0..255
  function automatic logic [7:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = (v + RND) >>> COEF_FRAC;
    if (s < 0)         return 8'd0;
    else if (s > MAXV) return 8'd255;
    else               return s[7:0];
  endfunction

  // Stage 3: registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= sat(r_sum);
      green <= sat(g_sum);
      blue  <= sat(b_sum);
    end
  end

`ifdef YCBCR_VALID_EN
  // No back-pressure: out_valid simply qualifies red/green/blue on the same cycle.
  logic [2:0] vld_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_sr <= '0;
    else      vld_sr <= {vld_sr[1:0], in_valid};
  end

  assign out_valid = vld_sr[2];
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb_conv.sv
// Scoreboard bench for ycbcr_to_rgb_conv: driver pushes expected pixels,
// a negedge monitor pops and compares when a tagged pixel reaches the output.
module tb_ycbcr_to_rgb_conv;

  // Entry: {tolerance[1:0], red, green, blue}
  localparam int W = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] y = '0, cb = '0, cr = '0;
  logic [7:0] red, green, blue;
  logic       tag_in = 1'b0;
  logic [2:0] tag_d;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

`ifdef YCBCR_VALID_EN
  logic in_valid;
  logic out_valid;
  assign in_valid = tag_in;
`endif

  ycbcr_to_rgb_conv dut (
    .clk      (clk),
    .rst      (rst),
    .y        (y),
    .cb       (cb),
    .cr       (cr),
`ifdef YCBCR_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  // Clock / reset-aware latency tag line
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) tag_d <= '0;
    else      tag_d <= {tag_d[1:0], tag_in};
  end

  task automatic chk_chan(input string name, input logic [7:0] act,
                          input logic [7:0] expv, input int tol);
    int d;
    d = int'(act) - int'(expv);
    checks++;
    if ($isunknown(act) || d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, expv, tol, $time);
    end
  endtask

  function automatic logic [7:0] clampr(input real v);
    if (v < 0.0)        return 8'd0;
    else if (v > 255.0) return 8'd255;
    else                return 8'($rtoi(v + 0.5));
  endfunction

  // Real-valued reference conversion
  function automatic logic [23:0] ref_rgb(input int yv, input int cbv, input int crv);
    real yy, rr, gg, bb;
    yy = 1.164 * real'(yv - 16);
    rr = yy + 1.596 * real'(crv - 128);
    gg = yy - 0.813 * real'(crv - 128) - 0.392 * real'(cbv - 128);
    bb = yy + 2.017 * real'(cbv - 128);
    return {clampr(rr), clampr(gg), clampr(bb)};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst && tag_d[2]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d/%0d/%0d with empty queue", red, green, blue);
      end else begin
        e = exp_q.pop_front();
        chk_chan("red",   red,   e[23:16], int'(e[25:24]));
        chk_chan("green", green, e[15:8],  int'(e[25:24]));
        chk_chan("blue",  blue,  e[7:0],   int'(e[25:24]));
      end
    end
`ifdef YCBCR_VALID_EN
    if (rst) begin
      checks++;
      if (out_valid !== tag_d[2]) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, tag_d[2], $time);
      end
    end
`endif
  end

  // Driver
  task automatic drive(input int yv, input int cbv, input int crv,
                       input logic chk, input logic [W-1:0] ev);
    @(negedge clk);
    y = 8'(yv);
    cb = 8'(cbv);
    cr = 8'(crv);
    tag_in = chk;
    if (chk) exp_q.push_back(ev);
  endtask

  task automatic drive_ref(input int yv, input int cbv, input int crv, input logic [1:0] tol);
    drive(yv, cbv, crv, 1'b1, {tol, ref_rgb(yv, cbv, crv)});
  endtask

  initial begin
    int yr, cbr, crr, wait_cnt;

    #1;
    chk_chan("reset_red",   red,   8'd0, 0);
    chk_chan("reset_green", green, 8'd0, 0);
    chk_chan("reset_blue",  blue,  8'd0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed vectors, exact fixed-point results
    drive(16,  128, 128, 1'b1, {2'd0, 8'd0,   8'd0,   8'd0});
    drive(235, 128, 128, 1'b1, {2'd0, 8'd255, 8'd255, 8'd255});
    drive(255, 255, 255, 1'b1, {2'd0, 8'd255, 8'd125, 8'd255});
    drive(255, 0,   0,   1'b1, {2'd0, 8'd74,  8'd255, 8'd20});
    drive(0,   0,   0,   1'b1, {2'd0, 8'd0,   8'd136, 8'd0});
    drive(128, 128, 128, 1'b1, {2'd0, 8'd130, 8'd130, 8'd130});
    drive(16,  128, 255, 1'b1, {2'd0, 8'd203, 8'd0,   8'd0});
    drive(16,  255, 128, 1'b1, {2'd0, 8'd0,   8'd0,   8'd255});

    // Back-to-back ramp, one pixel per clock
    for (int yv = 16; yv <= 235; yv++) drive_ref(yv, 128, 128, 2'd1);

    // Random pixels
    for (int i = 0; i < 300; i++) begin
      yr  = $urandom_range(0, 255);
      cbr = $urandom_range(0, 255);
      crr = $urandom_range(0, 255);
      drive_ref(yr, cbr, crr, 2'd2);
    end

    // Mid-stream asynchronous reset
    repeat (3) drive(200, 50, 90, 1'b0, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_chan("rst_async_red",   red,   8'd0, 0);
    chk_chan("rst_async_green", green, 8'd0, 0);
    chk_chan("rst_async_blue",  blue,  8'd0, 0);
    repeat (2) @(negedge clk);
    chk_chan("rst_hold_red",   red,   8'd0, 0);
    chk_chan("rst_hold_green", green, 8'd0, 0);
    chk_chan("rst_hold_blue",  blue,  8'd0, 0);
    rst = 1'b1;
    drive(235, 128, 128, 1'b1, {2'd0, 8'd255, 8'd255, 8'd255});
    drive(255, 0,   0,   1'b1, {2'd0, 8'd74,  8'd255, 8'd20});
    drive(0,   0,   0,   1'b1, {2'd0, 8'd0,   8'd136, 8'd0});
    drive(0, 0, 0, 1'b0, '0);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ycbcr_to_rgb_conv.md
Name: ycbcr_to_rgb_conv

Overview:
Pipelined colour-space converter from 8-bit ITU-R BT.601 studio-range YCbCr to 8-bit full-range RGB.
- Accepts one pixel per clock and produces one RGB pixel per clock after a fixed latency.
- Sits in the video datapath between the decoder/scaler output and the display/RGB sink.
- Purely arithmetic; no flow control or back-pressure.

Parameters:
COEF_FRAC, 10, fractional bits of fixed-point coefficients (coefficient = round(real × 2^COEF_FRAC)).
LATENCY, 3, input-to-output pipeline depth in clocks (fixed; not user-changeable, informational).

Ports:
clk  input  1  rising-edge clock, single clock domain.
rst  input  1  asynchronous, active-low reset (asserted when 0).
y  input  8  luma, unsigned, nominal range 16..235.
cb  input  8  blue-difference chroma, unsigned, offset 128.
cr  input  8  red-difference chroma, unsigned, offset 128.
red  output  8  red component, unsigned, 0..255.
green  output  8  green component, unsigned, 0..255.
blue  output  8  blue component, unsigned, 0..255.

Behaviour:
- Reference math (real):
  - R = 1.164(Y-16) + 1.596(Cr-128)
  - G = 1.164(Y-16) - 0.813(Cr-128) - 0.392(Cb-128)
  - B = 1.164(Y-16) + 2.017(Cb-128)
  - Each result is clamped to [0,255].
- Fixed point, COEF_FRAC=10:
  - Coefficients: 1192 (Y), 1634 (Cr→R), 833 (Cr→G), 401 (Cb→G), 2065 (Cb→B).
  - Subtract offsets as signed 9-bit values: Y-16 → -16..239; Cb-128 and Cr-128 → -128..127.
  - Products and sums in signed arithmetic wide enough for no overflow; ≥21 bits is sufficient.
  - Round by adding 2^(COEF_FRAC-1) before the arithmetic right shift by COEF_FRAC.
  - Saturate: negative → 0; >255 → 255; otherwise the low 8 bits.
- Accuracy: every output is within ±2 LSB of the clamped real reference for all 2^24 inputs; target is ±1.
- Pipeline, 3 register stages, fully pipelined with throughput 1 pixel/clk:
  - Stage 1 registers the offset-removed operands.
  - Stage 2 registers the products and partial sums.
  - Stage 3 registers the rounded, saturated 8-bit outputs.
- Timing: inputs sampled at rising edge k appear on red/green/blue after rising edge k+2 and are stable through edge k+3.
  - For inputs held constant ≥3 clocks, outputs equal the converted value from the 3rd edge onward.
- Reset:
  - While rst=0, all pipeline registers and red/green/blue are 0, asynchronously.
  - After release, the first valid outputs appear 3 edges after the first sampled input.
  - Reset asserted mid-stream clears the outputs immediately; in-flight pixels are discarded.
- No X propagation from reset state; the outputs are always registered, never combinational from the inputs.

Optional Feature:
Macro YCBCR_VALID_EN.
- Defined: adds input in_valid (1 bit) and output out_valid (1 bit).
  - in_valid is delayed through a 3-stage shift register aligned with the data.
  - out_valid resets to 0.
  - Data path is unchanged; out_valid qualifies red/green/blue.
- Undefined: no valid ports; every output cycle is treated as valid.

Test Plan:
- y=16, cb=128, cr=128 held 3 clks -> red=0, green=0, blue=0; y=235, cb=128, cr=128 -> 255/255/255 (±1).
- y=255, cb=255, cr=255 -> red=255 (clamp), green=125, blue=255 (clamp), each ±2.
- y=255, cb=0, cr=0 -> red=74, green=255 (clamp), blue=20, each ±2; y=0, cb=0, cr=0 -> red=0, green=136, blue=0, each ±2.
- Latency/throughput: new pixel every clock (ramp y=16..235, cb=cr=128) -> output sequence identical to the per-pixel results, offset exactly 3 clocks, no gaps.
- Reset: drive non-zero pixels, assert rst=0 asynchronously mid-clock -> red/green/blue become 0 immediately and stay 0; release -> correct results 3 edges after release.
- Random: 1,000,000 random y/cb/cr, each held 3 clks -> |out - clamped real reference| ≤ 2 on all three channels; with YCBCR_VALID_EN, out_valid tracks in_valid delayed 3 clks.
